// File: rtl/mv_candidate_gen_if.sv
// Candidate-generator bus: start/base request, stall backpressure and the
// registered candidate stream feeding the MV_X / MV_Y holding registers.
interface mv_candidate_gen_if #(
    parameter int unsigned MV_W = 19
);
    logic                   START;
    logic signed [MV_W-1:0] MV_BASE_X;
    logic signed [MV_W-1:0] MV_BASE_Y;
    logic                   STALL;
    logic signed [MV_W-1:0] MV_X;
    logic signed [MV_W-1:0] MV_Y;
    logic                   WRITE_EN;
    logic [4:0]             CAND_IDX;
    logic                   BUSY;
    logic                   DONE;

    modport master (
        output START, MV_BASE_X, MV_BASE_Y, STALL,
        input  MV_X, MV_Y, WRITE_EN, CAND_IDX, BUSY, DONE
    );

    modport slave (
        input  START, MV_BASE_X, MV_BASE_Y, STALL,
        output MV_X, MV_Y, WRITE_EN, CAND_IDX, BUSY, DONE
    );
endinterface

// File: rtl/mv_candidate_gen.sv
// Fractional-MV candidate generator: walks a raster grid around a captured base MV.
// Define QPEL_GRID_EN for the 5x5 quarter-pel grid; default is the 3x3 grid.
module mv_candidate_gen #(
    parameter int unsigned MV_W = 19,
    parameter int unsigned STEP = 2
) (
    input logic              CLK,
    input logic              RST_ASYNC,
    mv_candidate_gen_if.slave bus
);
`ifdef QPEL_GRID_EN
    localparam int unsigned GRID_N   = 5;
    localparam int unsigned OFF_UNIT = STEP / 2;
`else
    localparam int unsigned GRID_N   = 3;
    localparam int unsigned OFF_UNIT = STEP;
`endif
    localparam int unsigned CTR_W  = 3;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned SUM_W  = MV_W + 1;
    localparam int unsigned CENTER = GRID_N / 2;

    localparam logic signed [MV_W-1:0] SAT_MAX = {1'b0, {(MV_W-1){1'b1}}};
    localparam logic signed [MV_W-1:0] SAT_MIN = {1'b1, {(MV_W-1){1'b0}}};
    localparam logic [CTR_W-1:0]       CTR_LAST = CTR_W'(GRID_N - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CTR_W-1:0]       ix_q, ix_d;
    logic [CTR_W-1:0]       iy_q, iy_d;
    logic [IDX_W-1:0]       cnt_q, cnt_d;
    logic signed [MV_W-1:0] base_x_q, base_x_d;
    logic signed [MV_W-1:0] base_y_q, base_y_d;
    logic signed [MV_W-1:0] mv_x_q, mv_x_d;
    logic signed [MV_W-1:0] mv_y_q, mv_y_d;
    logic [IDX_W-1:0]       cand_idx_q, cand_idx_d;
    logic                   we_q, we_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    // Grid counter position -> signed offset centred on the base.
    function automatic logic signed [SUM_W-1:0] grid_off(input logic [CTR_W-1:0] c);
        logic signed [SUM_W-1:0] pos;
        pos = $signed(SUM_W'(c)) - $signed(SUM_W'(CENTER));
        return pos * $signed(SUM_W'(OFF_UNIT));
    endfunction

    // One extra bit of headroom, then clamp instead of wrapping.
    function automatic logic signed [MV_W-1:0] sat_add(
        input logic signed [MV_W-1:0]  base,
        input logic signed [SUM_W-1:0] off
    );
        logic [SUM_W-1:0] sum;
        sum = {base[MV_W-1], base} + off;
        if (sum[SUM_W-1] != sum[SUM_W-2]) begin
            return sum[SUM_W-1] ? SAT_MIN : SAT_MAX;
        end
        return $signed(sum[MV_W-1:0]);
    endfunction

    always_comb begin
        state_d    = state_q;
        ix_d       = ix_q;
        iy_d       = iy_q;
        cnt_d      = cnt_q;
        base_x_d   = base_x_q;
        base_y_d   = base_y_q;
        mv_x_d     = mv_x_q;
        mv_y_d     = mv_y_q;
        cand_idx_d = cand_idx_q;
        we_d       = 1'b0;
        busy_d     = (state_q == RUN);
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.START) begin
                    base_x_d = bus.MV_BASE_X;
                    base_y_d = bus.MV_BASE_Y;
                    ix_d     = '0;
                    iy_d     = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (!bus.STALL) begin
                    mv_x_d     = sat_add(base_x_q, grid_off(ix_q));
                    mv_y_d     = sat_add(base_y_q, grid_off(iy_q));
                    cand_idx_d = cnt_q;
                    we_d       = 1'b1;
                    cnt_d      = cnt_q + IDX_W'(1);
                    // dx is the inner loop, dy the outer
                    if (ix_q == CTR_LAST) begin
                        ix_d = '0;
                        if (iy_q == CTR_LAST) begin
                            state_d = FINISH;
                        end else begin
                            iy_d = iy_q + CTR_W'(1);
                        end
                    end else begin
                        ix_d = ix_q + CTR_W'(1);
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST_ASYNC) begin
        if (RST_ASYNC) begin
            state_q    <= IDLE;
            ix_q       <= '0;
            iy_q       <= '0;
            cnt_q      <= '0;
            base_x_q   <= '0;
            base_y_q   <= '0;
            mv_x_q     <= '0;
            mv_y_q     <= '0;
            cand_idx_q <= '0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ix_q       <= ix_d;
            iy_q       <= iy_d;
            cnt_q      <= cnt_d;
            base_x_q   <= base_x_d;
            base_y_q   <= base_y_d;
            mv_x_q     <= mv_x_d;
            mv_y_q     <= mv_y_d;
            cand_idx_q <= cand_idx_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.MV_X     = mv_x_q;
    assign bus.MV_Y     = mv_y_q;
    assign bus.WRITE_EN = we_q;
    assign bus.CAND_IDX = cand_idx_q;
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;

endmodule

// File: tb/tb_mv_candidate_gen.sv
// Directed, table-driven bench for mv_candidate_gen (3x3 default grid, or the
// 5x5 grid when QPEL_GRID_EN is defined).
module tb_mv_candidate_gen;
    localparam int unsigned MV_W = 19;
    localparam int unsigned STEP = 2;

    typedef struct {
        int bx;
        int by;
        int idx;
        int ex;
        int ey;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    vec_t tbl[$];

    mv_candidate_gen_if #(.MV_W(MV_W)) bus ();

    mv_candidate_gen #(.MV_W(MV_W), .STEP(STEP)) dut (
        .CLK       (clk),
        .RST_ASYNC (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int bx, input int by, input int idx, input int ex, input int ey);
        vec_t v;
        v.bx = bx; v.by = by; v.idx = idx; v.ex = ex; v.ey = ey;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sx();
        return int'($signed(bus.MV_X));
    endfunction

    function automatic int sy();
        return int'($signed(bus.MV_Y));
    endfunction

    // Run one walk for table rows [first, first+n); optional stall burst and ignored START.
    task automatic run_walk(input int first, input int n, input int stall_at,
                            input int stall_len, input int alt_at);
        int emitted;
        int stalled;
        int cyc;
        bit done_seen;
        bit stall_now;
        bit alt_sent;
        emitted   = 0;
        stalled   = 0;
        cyc       = 0;
        done_seen = 1'b0;
        alt_sent  = 1'b0;
        bus.MV_BASE_X = MV_W'(tbl[first].bx);
        bus.MV_BASE_Y = MV_W'(tbl[first].by);
        bus.START     = 1'b1;
        tick();
        bus.START     = 1'b0;
        bus.MV_BASE_X = '0;
        bus.MV_BASE_Y = '0;
        chk("busy_at_accept", int'(bus.BUSY), 0);
        chk("we_at_accept", int'(bus.WRITE_EN), 0);
        while (!done_seen && cyc < 80) begin
            stall_now = (emitted == stall_at) && (stalled < stall_len);
            bus.STALL = stall_now;
            if (stall_now) stalled++;
            if (emitted == alt_at && !alt_sent) begin
                alt_sent      = 1'b1;
                bus.START     = 1'b1;
                bus.MV_BASE_X = MV_W'(500);
                bus.MV_BASE_Y = MV_W'(-500);
            end
            tick();
            cyc++;
            bus.STALL = 1'b0;
            bus.START = 1'b0;
            if (bus.DONE) begin
                done_seen = 1'b1;
                chk("done_cycle", cyc, n + 1 + stall_len);
                chk("done_count", emitted, n);
                chk("busy_at_done", int'(bus.BUSY), 0);
                chk("we_at_done", int'(bus.WRITE_EN), 0);
                chk("hold_x_at_done", sx(), tbl[first+n-1].ex);
                chk("hold_y_at_done", sy(), tbl[first+n-1].ey);
            end else begin
                chk("busy_run", int'(bus.BUSY), 1);
                if (stall_now) begin
                    chk("we_stall", int'(bus.WRITE_EN), 0);
                    if (emitted > 0) begin
                        chk("idx_hold_stall", int'(bus.CAND_IDX), tbl[first+emitted-1].idx);
                        chk("x_hold_stall", sx(), tbl[first+emitted-1].ex);
                    end
                end else if (emitted >= n) begin
                    chk("done_missing", int'(bus.DONE), 1);
                end else begin
                    chk("we_run", int'(bus.WRITE_EN), 1);
                    chk("cand_idx", int'(bus.CAND_IDX), tbl[first+emitted].idx);
                    chk("mv_x", sx(), tbl[first+emitted].ex);
                    chk("mv_y", sy(), tbl[first+emitted].ey);
                    emitted++;
                end
            end
        end
        if (!done_seen) chk("walk_timeout", cyc, -1);
        tick();
        chk("done_pulse_end", int'(bus.DONE), 0);
        chk("we_after_done", int'(bus.WRITE_EN), 0);
        chk("hold_x_after", sx(), tbl[first+n-1].ex);
    endtask

    // Abort a walk at index 3 with the async reset, then verify a clean restart.
    task automatic reset_mid_walk(input int n);
        int cyc;
        cyc = 0;
        bus.MV_BASE_X = MV_W'(tbl[0].bx);
        bus.MV_BASE_Y = MV_W'(tbl[0].by);
        bus.START     = 1'b1;
        tick();
        bus.START = 1'b0;
        while (!(bus.WRITE_EN && bus.CAND_IDX == 5'd3) && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("reach_idx3", int'(bus.CAND_IDX), 3);
        #2 rst = 1'b1;
        #1;
        chk("rst_mv_x", sx(), 0);
        chk("rst_mv_y", sy(), 0);
        chk("rst_we", int'(bus.WRITE_EN), 0);
        chk("rst_idx", int'(bus.CAND_IDX), 0);
        chk("rst_busy", int'(bus.BUSY), 0);
        chk("rst_done", int'(bus.DONE), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_idle_we", int'(bus.WRITE_EN), 0);
        chk("post_rst_idle_busy", int'(bus.BUSY), 0);
        run_walk(0, n, -1, 0, -1);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.START     = 1'b0;
        bus.STALL     = 1'b0;
        bus.MV_BASE_X = '0;
        bus.MV_BASE_Y = '0;

`ifdef QPEL_GRID_EN
        for (int i = 0; i < 25; i++) tbl.push_back(mk(0, 0, i, (i % 5) - 2, (i / 5) - 2));
`else
        // base (100, -40)
        tbl.push_back(mk(100, -40, 0,  98, -42));
        tbl.push_back(mk(100, -40, 1, 100, -42));
        tbl.push_back(mk(100, -40, 2, 102, -42));
        tbl.push_back(mk(100, -40, 3,  98, -40));
        tbl.push_back(mk(100, -40, 4, 100, -40));
        tbl.push_back(mk(100, -40, 5, 102, -40));
        tbl.push_back(mk(100, -40, 6,  98, -38));
        tbl.push_back(mk(100, -40, 7, 100, -38));
        tbl.push_back(mk(100, -40, 8, 102, -38));
        // base (max, min): x clamps high, y clamps low
        tbl.push_back(mk(262143, -262144, 0, 262141, -262144));
        tbl.push_back(mk(262143, -262144, 1, 262143, -262144));
        tbl.push_back(mk(262143, -262144, 2, 262143, -262144));
        tbl.push_back(mk(262143, -262144, 3, 262141, -262144));
        tbl.push_back(mk(262143, -262144, 4, 262143, -262144));
        tbl.push_back(mk(262143, -262144, 5, 262143, -262144));
        tbl.push_back(mk(262143, -262144, 6, 262141, -262142));
        tbl.push_back(mk(262143, -262144, 7, 262143, -262142));
        tbl.push_back(mk(262143, -262144, 8, 262143, -262142));
        // base (-3, 5)
        tbl.push_back(mk(-3, 5, 0, -5, 3));
        tbl.push_back(mk(-3, 5, 1, -3, 3));
        tbl.push_back(mk(-3, 5, 2, -1, 3));
        tbl.push_back(mk(-3, 5, 3, -5, 5));
        tbl.push_back(mk(-3, 5, 4, -3, 5));
        tbl.push_back(mk(-3, 5, 5, -1, 5));
        tbl.push_back(mk(-3, 5, 6, -5, 7));
        tbl.push_back(mk(-3, 5, 7, -3, 7));
        tbl.push_back(mk(-3, 5, 8, -1, 7));
        // base (min, max): x clamps low, y clamps high
        tbl.push_back(mk(-262144, 262143, 0, -262144, 262141));
        tbl.push_back(mk(-262144, 262143, 1, -262144, 262141));
        tbl.push_back(mk(-262144, 262143, 2, -262142, 262141));
        tbl.push_back(mk(-262144, 262143, 3, -262144, 262143));
        tbl.push_back(mk(-262144, 262143, 4, -262144, 262143));
        tbl.push_back(mk(-262144, 262143, 5, -262142, 262143));
        tbl.push_back(mk(-262144, 262143, 6, -262144, 262143));
        tbl.push_back(mk(-262144, 262143, 7, -262144, 262143));
        tbl.push_back(mk(-262144, 262143, 8, -262142, 262143));
`endif

        #1;
        chk("reset_mv_x", sx(), 0);
        chk("reset_mv_y", sy(), 0);
        chk("reset_we", int'(bus.WRITE_EN), 0);
        chk("reset_idx", int'(bus.CAND_IDX), 0);
        chk("reset_busy", int'(bus.BUSY), 0);
        chk("reset_done", int'(bus.DONE), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

`ifdef QPEL_GRID_EN
        run_walk(0, 25, -1, 0, -1);
        run_walk(0, 25, 12, 2, -1);
        run_walk(0, 25, -1, 0, 6);
        reset_mid_walk(25);
`else
        for (int w = 0; w < 4; w++) run_walk(w * 9, 9, -1, 0, -1);
        run_walk(0, 9, 5, 3, -1);
        run_walk(18, 9, 0, 2, -1);
        run_walk(0, 9, -1, 0, 2);
        run_walk(9, 9, 8, 1, 4);
        reset_mid_walk(9);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0t expected=finish", $time);
        $fatal(1, "timeout");
    end
endmodule
